core_coproc_dispatch: RTL and testbench
=======================================

CORE_COPROC_DISPATCH -- requirements
Module: core_coproc_dispatch

Interface
REQ-001 SHALL have parameter NUM_CP, default 2, number of coprocessor channels (1..8).
REQ-002 SHALL have parameter CP_BASE, default 14, coprocessor number served by channel 0; channel i serves CP_BASE+i.
REQ-003 SHALL have parameter TIMEOUT, default 15, max WAIT cycles without ack (1..255).
REQ-004 SHALL have ports:
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous, active-high reset
 start  in  1  core issues coprocessor transfer (MCR/MRC)
 insn  in  32  full instruction; CP number insn[11:8]
 wdata  in  32  core Rd value for MCR
 stall  out  1  core must hold pipeline
 done  out  1  one-cycle completion pulse
 undefined  out  1  one-cycle undefined-instruction pulse
 rd  out  4  destination register of completed MRC
 writeback  out  1  with done: MRC with rd != R15
 update_flags  out  1  with done: MRC with rd == R15, NZCV = rdata[31:28]
 rdata  out  32  captured coprocessor read data
 cp_req  out  NUM_CP  one-hot request to selected channel
 cp_decode  out  coproc_decode  crn, crm, op1, op2, load of latched insn
 cp_wdata  out  32  latched wdata
 cp_ack  in  NUM_CP  per-channel acknowledge
 cp_rdata  in  NUM_CP*32  per-channel read data, channel i at [32i+31:32i]

Function
REQ-005 SHALL implement states IDLE, WAIT, DONE, FAULT.
REQ-006 Start SHALL be accepted only in IDLE, DONE or FAULT; start in WAIT SHALL be ignored.
REQ-007 On accepted start SHALL latch insn fields, rd = insn[15:12], wdata and channel index = insn[11:8] - CP_BASE.
REQ-008 Accepted start with insn[11:8] outside [CP_BASE, CP_BASE+NUM_CP-1] SHALL go to FAULT; else to WAIT.
REQ-009 In WAIT, cp_req SHALL be one-hot on the selected channel; cp_decode and cp_wdata SHALL stay stable until exit.
REQ-010 In WAIT, cp_ack of the selected channel SHALL capture that channel's cp_rdata into rdata and go to DONE next cycle.
REQ-011 cp_ack on unselected channels, or in any state but WAIT, SHALL be ignored.
REQ-012 Timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack; reaching TIMEOUT SHALL go to FAULT and drop cp_req.
REQ-013 Ack in the same cycle the counter reaches TIMEOUT SHALL win (go to DONE).
REQ-014 DONE SHALL assert done for exactly one cycle; writeback = load && rd != 15; update_flags = load && rd == 15; both 0 for MCR.
REQ-015 FAULT SHALL assert undefined for exactly one cycle; done, writeback, update_flags SHALL be 0.
REQ-016 stall SHALL be 1 in WAIT and combinationally 1 in any cycle an accepted start occurs; else 0.
REQ-017 From DONE/FAULT, accepted start SHALL go directly to WAIT/FAULT (back-to-back, no IDLE bubble); else to IDLE.
REQ-018 Minimum latency: start cycle 0, cp_req cycle 1, ack cycle 1, done cycle 2.
REQ-019 rdata SHALL hold its value until the next captured ack.

Reset
REQ-020 rst SHALL force IDLE and clear cp_req, done, undefined, writeback, update_flags, stall, timeout counter, rdata, rd to 0 on the next edge.
REQ-021 rst during WAIT SHALL abort silently: cp_req low next cycle, no done or undefined pulse.

Structure
REQ-022 State enum and cp_num typedef (4 bits) SHALL live in the shared uarch package; coproc_decode reused from there; R15 constant from the ISA header.
REQ-023 Timeout counter SHALL be sub-module core_coproc_timer (clear, enable, expired), width $clog2(TIMEOUT+1).

Verification
REQ-024 MRC p15 (insn[11:8]=15), rd=3, ack at cycle 3 with rdata 0xDEADBEEF -> done cycle 4, writeback=1, rd=3, rdata=0xDEADBEEF, stall 1 in cycles 0..3.
REQ-025 MRC p14 rd=15, rdata 0xA0000000 -> done, update_flags=1, writeback=0.
REQ-026 MCR p15, wdata 0x12345678 -> cp_req=2'b10, cp_wdata stable until ack, done with writeback=0.
REQ-027 insn[11:8]=10 -> undefined pulse cycle 1, cp_req never set.
REQ-028 TIMEOUT=4, no ack -> cp_req cycles 1..4, undefined cycle 5; ack on channel 0 while channel 1 selected ignored.
REQ-029 rst in cycle 2 of WAIT -> cp_req 0 at cycle 3, no done/undefined; start asserted in DONE cycle -> new cp_req next cycle.

Source files
------------

// File: rtl/core_coproc_dispatch_pkg.sv
// Shared micro-architecture types for the coprocessor dispatch path.
// Provides the dispatch FSM state enum, the 4-bit coprocessor number type,
// the decoded MCR/MRC field bundle and the architectural R15 index.
package core_coproc_dispatch_pkg;

  // Architectural index of the PC; an MRC targeting it updates NZCV instead.
  localparam logic [3:0] ISA_R15 = 4'd15;

  // Coprocessor number as encoded in insn[11:8].
  typedef logic [3:0] cp_num_t;

  typedef enum logic [1:0] {
    CPD_IDLE  = 2'd0,
    CPD_WAIT  = 2'd1,
    CPD_DONE  = 2'd2,
    CPD_FAULT = 2'd3
  } cpd_state_e;

  // Fields of an MCR/MRC handed to the coprocessor.
  typedef struct packed {
    logic [3:0] crn;   // insn[19:16]
    logic [3:0] crm;   // insn[3:0]
    logic [2:0] op1;   // insn[23:21]
    logic [2:0] op2;   // insn[7:5]
    logic       load;  // insn[20]: 1 = MRC (coprocessor to core)
  } coproc_decode;

endpackage

// File: rtl/core_coproc_timer.sv
// Purpose: counts WAIT cycles without ack and flags the cycle the limit is hit.
// Latency: expired is combinational in the cycle the count reaches TIMEOUT.
// Backpressure: none; the owner gates counting with enable.
// Ports: clk, rst (sync, active-high), clear (restart count), enable (count
//        this cycle), expired (this enabled cycle is the TIMEOUT-th one).
module core_coproc_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The count would become TIMEOUT at the coming edge.
  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/core_coproc_dispatch.sv
// Purpose: dispatches core MCR/MRC transfers to one of NUM_CP coprocessor channels.
// Latency: start cycle 0, cp_req cycle 1, earliest done cycle 2 (ack in cycle 1).
// Backpressure: stall holds the core while waiting; a missing ack faults after TIMEOUT cycles.
// Ports: clk/rst (sync active-high); start/insn/wdata from core; stall, done,
//        undefined, rd, writeback, update_flags, rdata to core; cp_req,
//        cp_decode, cp_wdata to coprocessors; cp_ack, cp_rdata from them.
module core_coproc_dispatch
  import core_coproc_dispatch_pkg::*;
#(
  parameter int NUM_CP  = 2,
  parameter int CP_BASE = 14,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          insn,
  input  logic [31:0]          wdata,
  output logic                 stall,
  output logic                 done,
  output logic                 undefined,
  output logic [3:0]           rd,
  output logic                 writeback,
  output logic                 update_flags,
  output logic [31:0]          rdata,
  output logic [NUM_CP-1:0]    cp_req,
  output coproc_decode         cp_decode,
  output logic [31:0]          cp_wdata,
  input  logic [NUM_CP-1:0]    cp_ack,
  input  logic [NUM_CP*32-1:0] cp_rdata
);

  localparam int IDXW = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;

  cpd_state_e      r_state;
  cpd_state_e      w_state_nxt;
  logic [IDXW-1:0] r_chan;
  logic [3:0]      r_rd;
  coproc_decode    r_decode;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  cp_num_t         w_cp_num;
  logic            w_in_range;
  logic            w_wait;
  logic            w_accept;
  logic            w_ack;
  logic            w_expired;
  logic [31:0]     w_sel_rdata;
  logic [NUM_CP-1:0] w_req;
  logic            w_unused;

  assign w_cp_num   = insn[11:8];
  assign w_in_range = (int'(w_cp_num) >= CP_BASE) &&
                      (int'(w_cp_num) <= CP_BASE + NUM_CP - 1);
  assign w_wait     = (r_state == CPD_WAIT);
  // A start arriving while a transfer is outstanding is dropped; the core
  // is stalled then and must re-present it.
  assign w_accept   = start && !rst && !w_wait;
  assign w_unused   = ^{insn[31:24], insn[4]};

  // Only the selected channel may request, acknowledge or return data.
  always_comb begin
    w_req       = '0;
    w_ack       = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (int'(r_chan) == i) begin
        w_req[i]    = w_wait;
        w_ack       = w_wait && cp_ack[i];
        w_sel_rdata = cp_rdata[32*i +: 32];
      end
    end
  end

  core_coproc_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept && w_in_range),
    .enable  (w_wait && !w_ack),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CPD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    stall        = w_wait || w_accept;
    done         = 1'b0;
    undefined    = 1'b0;
    writeback    = 1'b0;
    update_flags = 1'b0;
    case (r_state)
      CPD_WAIT: begin
        // An ack in the expiry cycle still completes the transfer.
        if (w_ack) begin
          w_state_nxt = CPD_DONE;
        end else if (w_expired) begin
          w_state_nxt = CPD_FAULT;
        end
      end
      CPD_DONE: begin
        done         = 1'b1;
        writeback    = r_decode.load && (r_rd != ISA_R15);
        update_flags = r_decode.load && (r_rd == ISA_R15);
        w_state_nxt  = CPD_IDLE;
      end
      CPD_FAULT: begin
        undefined   = 1'b1;
        w_state_nxt = CPD_IDLE;
      end
      default: begin
        w_state_nxt = CPD_IDLE;
      end
    endcase
    // Accepted starts bypass IDLE so DONE/FAULT can chain back-to-back.
    if (w_accept) begin
      w_state_nxt = w_in_range ? CPD_WAIT : CPD_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan   <= '0;
      r_rd     <= '0;
      r_decode <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_chan         <= IDXW'(int'(w_cp_num) - CP_BASE);
        r_rd           <= insn[15:12];
        r_decode.crn   <= insn[19:16];
        r_decode.crm   <= insn[3:0];
        r_decode.op1   <= insn[23:21];
        r_decode.op2   <= insn[7:5];
        r_decode.load  <= insn[20];
        r_wdata        <= wdata;
      end
      if (w_ack) begin
        r_rdata <= w_sel_rdata;
      end
    end
  end

  assign cp_req    = w_req;
  assign cp_decode = r_decode;
  assign cp_wdata  = r_wdata;
  assign rd        = r_rd;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_core_coproc_dispatch.sv
// Bench for core_coproc_dispatch: directed MCR/MRC scenarios with literal
// expectations, plus a transaction-level reference compared every cycle.
module tb_core_coproc_dispatch;
  import core_coproc_dispatch_pkg::*;

  localparam int NUM_CP  = 2;
  localparam int CP_BASE = 14;
  localparam int TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  insn;
  logic [31:0]  wdata;
  logic         stall;
  logic         done;
  logic         undefined;
  logic [3:0]   rd;
  logic         writeback;
  logic         update_flags;
  logic [31:0]  rdata;
  logic [1:0]   cp_req;
  coproc_decode cp_decode;
  logic [31:0]  cp_wdata;
  logic [1:0]   cp_ack;
  logic [63:0]  cp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_coproc_dispatch #(
    .NUM_CP (NUM_CP),
    .CP_BASE(CP_BASE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .insn         (insn),
    .wdata        (wdata),
    .stall        (stall),
    .done         (done),
    .undefined    (undefined),
    .rd           (rd),
    .writeback    (writeback),
    .update_flags (update_flags),
    .rdata        (rdata),
    .cp_req       (cp_req),
    .cp_decode    (cp_decode),
    .cp_wdata     (cp_wdata),
    .cp_ack       (cp_ack),
    .cp_rdata     (cp_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference: one outstanding transfer at most; pulses last one cycle.
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_undef = 1'b0;
  bit          m_acc;
  bit          cmp_en  = 1'b0;
  int          m_waited = 0;
  int          m_chan   = 0;
  logic [31:0] m_insn  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_rd    = '0;

  always @(negedge clk) begin
    m_acc = start && !rst && !m_busy;
    if (cmp_en) begin
      chk("m.stall",        stall,        m_busy || m_acc);
      chk("m.cp_req",       cp_req,       m_busy ? (2'b01 << m_chan) : 2'b00);
      chk("m.done",         done,         m_done);
      chk("m.undefined",    undefined,    m_undef);
      chk("m.writeback",    writeback,    m_done && m_insn[20] && (m_rd != 4'd15));
      chk("m.update_flags", update_flags, m_done && m_insn[20] && (m_rd == 4'd15));
      chk("m.rd",           rd,           m_rd);
      chk("m.rdata",        rdata,        m_rdata);
      chk("m.cp_wdata",     cp_wdata,     m_wdata);
      chk("m.crn",          cp_decode.crn,  m_insn[19:16]);
      chk("m.crm",          cp_decode.crm,  m_insn[3:0]);
      chk("m.op1",          cp_decode.op1,  m_insn[23:21]);
      chk("m.op2",          cp_decode.op2,  m_insn[7:5]);
      chk("m.load",         cp_decode.load, m_insn[20]);
    end
    // Advance the reference across the coming rising edge.
    if (rst) begin
      m_busy = 0; m_done = 0; m_undef = 0; m_waited = 0; m_chan = 0;
      m_insn = '0; m_wdata = '0; m_rdata = '0; m_rd = '0;
      cmp_en = 1'b1;
    end else begin
      m_done  = 0;
      m_undef = 0;
      if (m_busy) begin
        if (cp_ack[m_chan]) begin
          m_rdata = cp_rdata[32*m_chan +: 32];
          m_busy  = 0;
          m_done  = 1;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_busy  = 0;
            m_undef = 1;
          end
        end
      end else if (start) begin
        m_insn  = insn;
        m_wdata = wdata;
        m_rd    = insn[15:12];
        if (int'(insn[11:8]) >= CP_BASE && int'(insn[11:8]) < CP_BASE + NUM_CP) begin
          m_busy   = 1;
          m_chan   = int'(insn[11:8]) - CP_BASE;
          m_waited = 0;
        end else begin
          m_undef = 1;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; insn = '0; wdata = '0; cp_ack = '0; cp_rdata = '0;
    nxt(); nxt();
    mid();
    chk("reset stall",     stall,     1'b0);
    chk("reset cp_req",    cp_req,    2'b00);
    chk("reset done",      done,      1'b0);
    chk("reset undefined", undefined, 1'b0);
    chk("reset rdata",     rdata,     32'h0);
    chk("reset rd",        rd,        4'h0);
    nxt(); rst = 1'b0;
    nxt();

    // MRC p15 rd=3, ack in cycle 3
    cp_rdata = {32'hDEADBEEF, 32'h11111111};
    start = 1'b1; insn = 32'hEE103F10; wdata = 32'hCAFE0000;
    mid(); chk("mrc15 c0 stall", stall, 1'b1);
    nxt(); start = 1'b0; insn = '0; wdata = '0;
    mid(); chk("mrc15 c1 cp_req", cp_req, 2'b10); chk("mrc15 c1 stall", stall, 1'b1);
    nxt();
    mid(); chk("mrc15 c2 stall", stall, 1'b1);
    nxt(); cp_ack = 2'b10;
    mid(); chk("mrc15 c3 stall", stall, 1'b1);
    nxt(); cp_ack = 2'b00;
    mid();
    chk("mrc15 c4 done", done, 1'b1);
    chk("mrc15 c4 writeback", writeback, 1'b1);
    chk("mrc15 c4 update_flags", update_flags, 1'b0);
    chk("mrc15 c4 rd", rd, 4'd3);
    chk("mrc15 c4 rdata", rdata, 32'hDEADBEEF);
    chk("mrc15 c4 stall", stall, 1'b0);
    // Acks while idle must not disturb rdata.
    nxt(); cp_ack = 2'b11; cp_rdata = {32'h55555555, 32'h66666666};
    mid(); chk("idle ack done", done, 1'b0); chk("idle ack rdata", rdata, 32'hDEADBEEF);
    nxt(); cp_ack = 2'b00;

    // MRC p14 rd=15, minimum latency
    start = 1'b1; insn = 32'hEE10FE10; cp_rdata = {32'h0, 32'hA0000000};
    mid(); nxt(); start = 1'b0; cp_ack = 2'b01;
    mid(); chk("mrc14 c1 cp_req", cp_req, 2'b01);
    nxt(); cp_ack = 2'b00;
    mid();
    chk("mrc14 c2 done", done, 1'b1);
    chk("mrc14 c2 update_flags", update_flags, 1'b1);
    chk("mrc14 c2 writeback", writeback, 1'b0);
    chk("mrc14 c2 rdata", rdata, 32'hA0000000);
    chk("mrc14 c2 rd", rd, 4'd15);
    nxt();

    // MCR p15; start held into WAIT with new operands is ignored
    start = 1'b1; insn = 32'hEE005F10; wdata = 32'h12345678; cp_rdata = {32'h0BADF00D, 32'h0};
    mid(); nxt(); insn = 32'hEE103E10; wdata = 32'hFFFFFFFF;
    mid(); chk("mcr c1 cp_req", cp_req, 2'b10); chk("mcr c1 cp_wdata", cp_wdata, 32'h12345678);
    nxt(); start = 1'b0; cp_ack = 2'b10;
    mid(); chk("mcr c2 cp_wdata", cp_wdata, 32'h12345678); chk("mcr c2 load", cp_decode.load, 1'b0);
    nxt(); cp_ack = 2'b00;
    mid();
    chk("mcr c3 done", done, 1'b1);
    chk("mcr c3 writeback", writeback, 1'b0);
    chk("mcr c3 update_flags", update_flags, 1'b0);
    nxt();

    // Unserved CP 10, then chained start from FAULT
    start = 1'b1; insn = 32'hEE103A10;
    mid(); chk("cp10 c0 stall", stall, 1'b1);
    nxt(); insn = 32'hEE102E10;
    mid(); chk("cp10 c1 undefined", undefined, 1'b1); chk("cp10 c1 cp_req", cp_req, 2'b00);
    chk("cp10 c1 done", done, 1'b0);
    nxt(); start = 1'b0; cp_ack = 2'b01;
    mid(); chk("cp10 c2 undefined", undefined, 1'b0); chk("fault chain c2 cp_req", cp_req, 2'b01);
    nxt(); cp_ack = 2'b00;
    mid(); chk("fault chain c3 done", done, 1'b1);
    nxt();

    // Timeout on channel 1, stray ack on channel 0
    start = 1'b1; insn = 32'hEE103F10;
    mid(); nxt(); start = 1'b0;
    mid(); chk("tmo c1 cp_req", cp_req, 2'b10);
    nxt(); cp_ack = 2'b01;
    mid(); chk("tmo c2 cp_req", cp_req, 2'b10);
    nxt(); cp_ack = 2'b00;
    nxt();
    mid(); chk("tmo c4 cp_req", cp_req, 2'b10); chk("tmo c4 stall", stall, 1'b1);
    nxt();
    mid(); chk("tmo c5 undefined", undefined, 1'b1); chk("tmo c5 cp_req", cp_req, 2'b00);
    chk("tmo c5 done", done, 1'b0); chk("tmo c5 stall", stall, 1'b0);
    nxt();

    // Ack in the expiry cycle wins
    cp_rdata = {32'h13579BDF, 32'h0}; start = 1'b1; insn = 32'hEE107F10;
    mid(); nxt(); start = 1'b0;
    nxt(); nxt(); nxt(); cp_ack = 2'b10;
    mid(); chk("race c4 cp_req", cp_req, 2'b10);
    nxt(); cp_ack = 2'b00;
    mid(); chk("race c5 done", done, 1'b1); chk("race c5 undefined", undefined, 1'b0);
    chk("race c5 rdata", rdata, 32'h13579BDF); chk("race c5 rd", rd, 4'd7);
    nxt();

    // Reset in WAIT aborts silently
    start = 1'b1; insn = 32'hEE101E10;
    mid(); nxt(); start = 1'b0;
    nxt(); rst = 1'b1;
    mid(); chk("rstw c2 cp_req", cp_req, 2'b01);
    nxt(); rst = 1'b0;
    mid(); chk("rstw c3 cp_req", cp_req, 2'b00); chk("rstw c3 done", done, 1'b0);
    chk("rstw c3 undefined", undefined, 1'b0); chk("rstw c3 rdata", rdata, 32'h0);
    nxt();
    mid(); chk("rstw c4 done", done, 1'b0); chk("rstw c4 undefined", undefined, 1'b0);
    nxt();

    // Start in the DONE cycle chains straight into WAIT
    cp_rdata = {32'h00000088, 32'h00000077}; start = 1'b1; insn = 32'hEE102E10;
    mid(); nxt(); start = 1'b0; cp_ack = 2'b01;
    nxt(); cp_ack = 2'b00; start = 1'b1; insn = 32'hEE104F10;
    mid(); chk("b2b c2 done", done, 1'b1); chk("b2b c2 stall", stall, 1'b1);
    chk("b2b c2 rdata", rdata, 32'h77);
    nxt(); start = 1'b0; cp_ack = 2'b10;
    mid(); chk("b2b c3 cp_req", cp_req, 2'b10);
    nxt(); cp_ack = 2'b00;
    mid(); chk("b2b c4 done", done, 1'b1); chk("b2b c4 rd", rd, 4'd4);
    chk("b2b c4 rdata", rdata, 32'h88);
    nxt(); nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
